// File: rtl/ram_fifo_outbuf.sv
// Two-entry skid buffer that sits behind the RAM read port of ram_fifo_ctrl.
// A load strobe brings in the registered RAM word. A pop removes the head entry.
module ram_fifo_outbuf #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [width-1:0] load_data,
    input  logic             pop,
    output logic             valid,
    output logic [width-1:0] data,
    output logic [1:0]       count
);

    logic [width-1:0] head_q, head_d;
    logic [width-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             do_pop;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop && (count_q != 2'd0);
        case ({load, do_pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = load_data;
                else                 tail_d = load_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged. The new word goes wherever the head leaves room.
                if (count_q == 2'd1) begin
                    head_d = load_data;
                end else begin
                    head_d = tail_q;
                    tail_d = load_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign valid = (count_q != 2'd0);
    assign data  = head_q;
    assign count = count_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM that has a 1-cycle registered read, with a 2-entry output buffer.
// Optional occupancy output `level`, present only when RAM_FIFO_LEVEL_EN is defined.
module ram_fifo_ctrl #(
    parameter int width   = 1,
    parameter int widthad = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [width-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [width-1:0]   out_data,
    input  logic               out_ready,
    output logic [widthad-1:0] ram_wraddress,
    output logic               ram_wren,
    output logic [width-1:0]   ram_data,
    output logic [widthad-1:0] ram_rdaddress,
    input  logic [width-1:0]   ram_q
`ifdef RAM_FIFO_LEVEL_EN
    ,
    output logic [widthad+1:0] level
`endif
);

    localparam logic [widthad:0]   CNT_FULL = {1'b1, {widthad{1'b0}}};
    localparam logic [widthad:0]   CNT_ONE  = (widthad+1)'(1);
    localparam logic [widthad-1:0] PTR_ONE  = widthad'(1);

    logic [widthad-1:0] wr_ptr_q, wr_ptr_d;
    logic [widthad-1:0] rd_ptr_q, rd_ptr_d;
    logic [widthad:0]   ram_count_q, ram_count_d;
    logic               rd_pending_q, rd_pending_d;
    logic [1:0]         buf_count;
    logic               push, pop, issue;

    assign in_ready      = (ram_count_q != CNT_FULL);
    assign push          = in_valid && in_ready;
    assign pop           = out_valid && out_ready;
    assign ram_wren      = push;
    assign ram_wraddress = wr_ptr_q;
    assign ram_data      = in_data;
    assign ram_rdaddress = rd_ptr_q;

    // Reads in flight plus buffered words never exceed two, so the buffer cannot overflow.
    assign issue = (ram_count_q != '0) &&
                   ((({1'b0, buf_count} + {2'b00, rd_pending_q}) < 3'd2) || pop);

    always_comb begin
        wr_ptr_d     = push  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d     = issue ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        rd_pending_d = issue;
        ram_count_d  = ram_count_q;
        case ({push, issue})
            2'b10:   ram_count_d = ram_count_q + CNT_ONE;
            2'b01:   ram_count_d = ram_count_q - CNT_ONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_count_q  <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_count_q  <= ram_count_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    ram_fifo_outbuf #(
        .width(width)
    ) u_outbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rd_pending_q),
        .load_data(ram_q),
        .pop      (pop),
        .valid    (out_valid),
        .data     (out_data),
        .count    (buf_count)
    );

`ifdef RAM_FIFO_LEVEL_EN
    logic [widthad+1:0] level_q, level_d;

    // The next-state sum keeps level aligned with the occupancy after each edge.
    always_comb begin
        level_d = (widthad+2)'(ram_count_d) + (widthad+2)'(rd_pending_d)
                + (widthad+2)'(buf_count) + (widthad+2)'(rd_pending_q)
                - (widthad+2)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_q <= '0;
        else        level_q <= level_d;
    end

    assign level = level_q;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl (width 8, widthad 2) with a behavioural registered-read RAM.
// A negedge monitor scoreboards every accepted word against the words delivered.
module tb_ram_fifo_ctrl;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, ram_wren;
    logic [7:0] out_data, ram_data;
    logic [7:0] ram_q;
    logic [1:0] ram_wraddress, ram_rdaddress;
`ifdef RAM_FIFO_LEVEL_EN
    logic [3:0] level;
`endif

    ram_fifo_ctrl #(.width(8), .widthad(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .ram_wraddress(ram_wraddress),
        .ram_wren     (ram_wren),
        .ram_data     (ram_data),
        .ram_rdaddress(ram_rdaddress),
        .ram_q        (ram_q)
`ifdef RAM_FIFO_LEVEL_EN
        ,
        .level        (level)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:3];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_wraddress] <= ram_data;
        ram_q <= mem[ram_rdaddress];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    logic [7:0] exp_q[$];
    int         n_acc = 0;
    int         n_pop = 0;
    logic       stall_q = 1'b0;
    logic [7:0] stall_data = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && out_valid) chk("hold", 32'(out_data), 32'(stall_data));
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                n_acc++;
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
                n_pop++;
            end
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int max_cyc);
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < max_cyc) begin
            tick();
            k++;
        end
        chk("drain", 32'(exp_q.size()), 0);
        chk("drain_idle", 32'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pop0, acc0, idx, k;
        logic acc;

        // reset state
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
`ifdef RAM_FIFO_LEVEL_EN
        chk("rst_level", 32'(level), 0);
`endif
        #2 rst_n = 1'b1;
        tick();

        // latency: accept at edge N, valid after N+2, popped at N+3
        in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_n0", 32'(out_valid), 0);
        tick();
        chk("lat_n1", 32'(out_valid), 0);
        tick();
        chk("lat_n2", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 32'h11);
        tick();
        chk("lat_n3", 32'(out_valid), 0);
        tick();

        // full: six words fit (four in RAM, two in the buffer)
        out_ready = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("full_acc", 32'(n_acc - acc0), 6);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_valid", 32'(out_valid), 1);
        chk("full_head", 32'(out_data), 0);
        if (exp_q.size() == 6) chk("full_last", 32'(exp_q[5]), 5);
        else chk("full_qsize", 32'(exp_q.size()), 6);
`ifdef RAM_FIFO_LEVEL_EN
        chk("full_level", 32'(level), 6);
`endif
        pop0 = n_pop;
        out_ready = 1'b1;
        wait_drain(30);
        chk("full_pops", 32'(n_pop - pop0), 6);
`ifdef RAM_FIFO_LEVEL_EN
        chk("empty_level", 32'(level), 0);
`endif
        tick();

        // streaming: 100 words, one per cycle, no gaps
        pop0 = n_pop;
        in_valid = 1'b1; in_data = 8'h40; out_ready = 1'b1;
        for (int c = 0; c < 104; c++) begin
            @(posedge clk);
            #1;
            chk("stream_valid", 32'(out_valid), 32'((c >= 2) && (c <= 101)));
            if (c < 100) chk("stream_in_ready", 32'(in_ready), 1);
            if (c < 99) in_data = 8'(8'h41 + c);
            else        in_valid = 1'b0;
        end
        chk("stream_pops", 32'(n_pop - pop0), 100);
        chk("stream_sb", 32'(exp_q.size()), 0);
        tick();

        // backpressure: out_ready toggles every cycle under continuous input
        pop0 = n_pop;
        idx = 0; k = 0;
        in_valid = 1'b1; in_data = 8'h80; out_ready = 1'b0;
        while (idx < 20 && k < 300) begin
            acc = in_valid && in_ready;
            tick();
            k++;
            if (acc) begin
                idx++;
                if (idx < 20) in_data = 8'(8'h80 + idx);
                else          in_valid = 1'b0;
            end
            out_ready = ~out_ready;
        end
        in_valid = 1'b0;
        chk("bp_acc", 32'(idx), 20);
        out_ready = 1'b1;
        wait_drain(60);
        chk("bp_pops", 32'(n_pop - pop0), 20);
        tick();

        // reset mid-operation with three words held
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h31 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("mid_held", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_data", 32'(out_data), 0);
`ifdef RAM_FIFO_LEVEL_EN
        chk("mid_rst_level", 32'(level), 0);
`endif
        exp_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 6) begin
            tick();
            k++;
        end
        chk("mid_first_valid", 32'(out_valid), 1);
        chk("mid_first_data", 32'(out_data), 32'hA5);
        tick();
        tick();
        chk("mid_after_valid", 32'(out_valid), 0);
        chk("mid_after_sb", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter width, default 1, data word width in bits.
REQ-002 SHALL have parameter widthad, default 1, RAM address width; RAM depth = 2**widthad.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  and in_data  input  width  (upstream write stream).
REQ-006 SHALL have port in_ready  output  1  high when a word can be accepted.
REQ-007 SHALL have port out_valid  output  1  and out_data  output  width  (downstream read stream).
REQ-008 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-009 SHALL have ports ram_wraddress output widthad, ram_wren output 1, ram_data output width, ram_rdaddress output widthad, ram_q input width; these drive a 1-cycle registered-read dual-port RAM.
REQ-010 SHALL have, only when RAM_FIFO_LEVEL_EN is defined, port level  output  widthad+2  current occupancy.

Function
REQ-011 SHALL accept a word on every edge where in_valid && in_ready; ram_wren = in_valid && in_ready, ram_wraddress = wr_ptr, ram_data = in_data (combinational).
REQ-012 SHALL derive in_ready only from registered state (ram_count != 2**widthad); no combinational path from out_ready or in_valid.
REQ-013 SHALL drive ram_rdaddress = rd_ptr continuously; ram_q is captured only on edges following an issued read (rd_pending).
REQ-014 SHALL issue a read when ram_count > 0 and (buf_count + rd_pending < 2, or out_valid && out_ready in the same cycle); issue increments rd_ptr, sets rd_pending, decrements ram_count.
REQ-015 SHALL hold a 2-entry output buffer; out_valid = (buf_count > 0); out_data = buffer head.
REQ-016 SHALL keep out_data stable while out_valid && !out_ready.
REQ-017 SHALL deliver words in strict acceptance order; no loss, no duplication.
REQ-018 SHALL have latency: word accepted at edge N into empty block -> out_valid high after edge N+2.
REQ-019 SHALL sustain one word per cycle in and out under continuous in_valid and out_ready.
REQ-020 SHALL wrap wr_ptr and rd_ptr modulo 2**widthad.
REQ-021 SHALL hold total capacity 2**widthad + 2 words (RAM plus output buffer).
REQ-022 SHALL apply push and issue in the same cycle as net-zero ram_count change; a push while full is ignored (in_ready low).
REQ-023 SHALL ignore out_ready while out_valid is low.

Reset
REQ-024 SHALL on rst_n low asynchronously clear wr_ptr, rd_ptr, ram_count, rd_pending, buf_count; out_valid = 0, in_ready = 1, level = 0.
REQ-025 SHALL discard any in-flight read on reset mid-operation; RAM contents are not cleared and are never re-read.
REQ-026 SHALL reset out_data register contents to 0.

Configuration
REQ-027 SHALL, with RAM_FIFO_LEVEL_EN defined, drive level = ram_count + rd_pending + buf_count, registered, updated every edge.
REQ-028 SHALL, without RAM_FIFO_LEVEL_EN, omit the level port and its logic; all other behaviour identical.

Structure
REQ-029 SHALL keep all constants local parameters; no shared package.
REQ-030 SHALL implement the output buffer as sub-module ram_fifo_outbuf (2-entry skid buffer, load strobe, pop, count).
REQ-031 SHALL not instantiate the RAM; the RAM is connected externally via the ram_* ports.

Verification (width=8, widthad=2, capacity 6, RAM model attached)
REQ-032 SHALL test reset: rst_n low mid-cycle -> out_valid 0, in_ready 1, level 0 immediately.
REQ-033 SHALL test latency: push 0x11 at edge N, out_ready 1 -> out_valid high after N+2, out_data 0x11, popped at N+3, out_valid low after.
REQ-034 SHALL test full: out_ready 0, push 0x00..0x07 continuously -> exactly 0x00..0x05 accepted, in_ready low, level 6; then out_ready 1 -> 0x00..0x05 out in order.
REQ-035 SHALL test streaming: in_valid 1, out_ready 1, 100 incrementing words -> after latency one word per cycle, no gaps, pointers wrap 25 times, order preserved.
REQ-036 SHALL test backpressure: out_ready toggles every cycle with continuous input -> out_data constant during each stall, sequence complete and in order.
REQ-037 SHALL test reset mid-operation: 3 words held, rst_n pulsed -> out_valid 0; after release push 0xA5 -> first output 0xA5.
